// File: rtl/div_pkg.sv
// Shared divider definitions: widths, FSM states and result-range helper.
// Used by the reconstruction unit and by the divider bench.
package div_pkg;

  localparam int QW = 16;
  localparam int DW = 8;
  localparam int PW = QW + DW;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // True when the reconstructed dividend has no bits above the 16-bit range
  function automatic logic fits16_chk(input logic [PW-1:0] v);
    return v[PW-1:QW] == '0;
  endfunction

endpackage

// File: rtl/div_recon_step.sv
// One shift-add multiply step: conditionally add the multiplicand,
// then advance multiplicand left and multiplier right.
module div_recon_step
  import div_pkg::*;
#(
  parameter int PW = div_pkg::PW,
  parameter int DW = div_pkg::DW
) (
  input  logic [PW-1:0] acc_i,
  input  logic [PW-1:0] mcand_i,
  input  logic [DW-1:0] mplier_i,
  output logic [PW-1:0] acc_o,
  output logic [PW-1:0] mcand_o,
  output logic [DW-1:0] mplier_o
);

  assign acc_o    = mplier_i[0] ? acc_i + mcand_i : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/div_recon_16bit.sv
// Sequential dividend reconstruction Q*B+R with an 8-step shift-add,
// plus range and remainder-legality flags; valid/ready on both sides.
module div_recon_16bit
  import div_pkg::*;
#(
  parameter int QW = div_pkg::QW,
  parameter int DW = div_pkg::DW,
  parameter int PW = QW + DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] quotient,
  input  logic [DW-1:0] divisor,
  input  logic [QW-1:0] remainder,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] dividend,
  output logic          fits16,
  output logic          rem_ok
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_e state_q, state_d;

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rem_ok_q, rem_ok_d;

  logic          accept;
  logic [PW-1:0] acc_s, mcand_s;
  logic [DW-1:0] mplier_s;

  assign accept = in_valid && in_ready;

  div_recon_step #(
    .PW(PW),
    .DW(DW)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplier_i(mplier_q),
    .acc_o   (acc_s),
    .mcand_o (mcand_s),
    .mplier_o(mplier_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (cnt_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // All DW steps always run; zero operands need no special case
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    rem_ok_d = rem_ok_q;
    if (accept) begin
      acc_d    = PW'(remainder);
      mcand_d  = PW'(quotient);
      mplier_d = divisor;
      cnt_d    = '0;
      rem_ok_d = remainder < QW'(divisor);
    end else if (state_q == CALC) begin
      acc_d    = acc_s;
      mcand_d  = mcand_s;
      mplier_d = mplier_s;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rem_ok_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      rem_ok_q <= rem_ok_d;
    end
  end

  assign dividend = acc_q;
  assign fits16   = fits16_chk(acc_q);
  assign rem_ok   = rem_ok_q;

endmodule

// File: tb/tb_div_recon_16bit.sv
// Self-checking bench for div_recon_16bit against a plain-arithmetic
// model of Q*B+R, range flag and remainder legality.
module tb_div_recon_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [15:0] remainder;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] dividend;
  logic        fits16;
  logic        rem_ok;

  int n_pass = 0;
  int n_total = 0;

  div_recon_16bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .quotient (quotient),
    .divisor  (divisor),
    .remainder(remainder),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dividend (dividend),
    .fits16   (fits16),
    .rem_ok   (rem_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_div(input int unsigned q,
                                            input int unsigned b,
                                            input int unsigned r);
    int unsigned p;
    p = q * b + r;
    return p[23:0];
  endfunction

  // Called #1 after an edge with the unit idle; returns #1 after accept
  task automatic start(input logic [15:0] q, input logic [7:0] b,
                       input logic [15:0] r);
    quotient  = q;
    divisor   = b;
    remainder = r;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    quotient  = 16'($urandom);
    divisor   = 8'($urandom);
    remainder = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    quotient = '0;
    divisor = '0;
    remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else n_pass++;
    n_total++;
    if ({dividend, fits16, rem_ok} !== {24'h0, 1'b1, 1'b0})
      $display("FAIL reset_out got %h %b %b want 000000 1 0",
               dividend, fits16, rem_ok);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] qs[4] = '{16'h1234, 16'd100, 16'hFFFF, 16'hFFFF};
    logic [7:0]  bs[4] = '{8'h56, 8'd7, 8'h00, 8'hFF};
    logic [15:0] rs[4] = '{16'h0012, 16'd3, 16'd5, 16'hFFFF};
    logic [23:0] ed[4] = '{24'h061D8A, 24'h0002BF, 24'h000005, 24'hFFFF00};
    logic        ef[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        er[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start(qs[i], bs[i], rs[i]);
      wait_done(lat);
      n_total++;
      if (lat !== 8) $display("FAIL dir%0d_latency got %0d want 8", i, lat);
      else n_pass++;
      n_total++;
      if ({dividend, fits16, rem_ok} !== {ed[i], ef[i], er[i]})
        $display("FAIL dir%0d_result got %h %b %b want %h %b %b", i,
                 dividend, fits16, rem_ok, ed[i], ef[i], er[i]);
      else n_pass++;
      ack();
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL dir%0d_idle got %b want 1", i, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    logic [23:0] exp;
    start(16'h0BAD, 8'h3C, 16'h0021);
    exp = model_div(16'h0BAD, 8'h3C, 16'h0021);
    wait_done(lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      quotient = 16'($urandom);
      divisor = 8'($urandom);
      remainder = 16'($urandom);
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && dividend === exp &&
            fits16 === 1'b0 && rem_ok === 1'b1)) bad++;
    end
    in_valid = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    else n_pass++;
    ack();
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else n_pass++;
    start(16'd500, 8'd9, 16'd4);
    wait_done(lat);
    n_total++;
    if (lat !== 8 || dividend !== 24'd4504 || rem_ok !== 1'b1)
      $display("FAIL bp_next got lat=%0d %h %b want 8 001198 1",
               lat, dividend, rem_ok);
    else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    start(16'hFFFF, 8'hFF, 16'h1111);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready, dividend} !== {1'b0, 1'b1, 24'h0})
      $display("FAIL rst_mid got vld=%b rdy=%b %h want 0 1 000000",
               out_valid, in_ready, dividend);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(16'd1000, 8'd13, 16'd12);
    wait_done(lat);
    n_total++;
    if (lat !== 8 || {dividend, fits16, rem_ok} !== {24'd13012, 1'b1, 1'b1})
      $display("FAIL rst_after got lat=%0d %h %b %b want 8 0032D4 1 1",
               lat, dividend, fits16, rem_ok);
    else n_pass++;
    ack();
  endtask

  task automatic test_random();
    int lat;
    int unsigned q, b, r;
    logic [23:0] exp;
    for (int i = 0; i < 200; i++) begin
      q = $urandom_range(0, 65535);
      b = $urandom_range(0, 255);
      r = $urandom_range(0, 65535);
      exp = model_div(q, b, r);
      start(16'(q), 8'(b), 16'(r));
      wait_done(lat);
      n_total++;
      if (lat !== 8 || dividend !== exp || fits16 !== (exp < 24'h10000) ||
          rem_ok !== (r < b))
        $display("FAIL rand%0d got lat=%0d %h %b %b want 8 %h %b %b", i, lat,
                 dividend, fits16, rem_ok, exp, exp < 24'h10000, r < b);
      else n_pass++;
      ack();
    end
  endtask

  task automatic test_round_trip();
    int lat;
    int unsigned a, b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 65535);
      b = $urandom_range(1, 255);
      start(16'(a / b), 8'(b), 16'(a % b));
      wait_done(lat);
      n_total++;
      if (lat !== 8 || dividend !== 24'(a) || fits16 !== 1'b1 || rem_ok !== 1'b1)
        $display("FAIL trip%0d got lat=%0d %h %b %b want 8 %h 1 1", i, lat,
                 dividend, fits16, rem_ok, 24'(a));
      else n_pass++;
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
